// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN selects rotating priority in place of fixed priority.
package sdram_arb_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;
  localparam int NPORT  = 3;

  localparam logic [1:0] PORT_CPU   = 2'd0;
  localparam logic [1:0] PORT_DL    = 2'd1;
  localparam logic [1:0] PORT_ERASE = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Modulo-3 successor used by the rotating search.
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= PORT_ERASE) ? PORT_CPU : p + 2'd1;
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection for the SDRAM arbiter.
// ARB_ROUND_ROBIN_EN: rotate from the last grant; otherwise fixed priority with starvation override.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic [2:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0] last_i,
`else
  input  logic [3:0] wait1_i,
  input  logic [3:0] wait2_i,
`endif
  output logic [1:0] idx_o,
  output logic       valid_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] c0, c1, c2;

  // Later assignments override earlier ones, so c0 has the highest priority.
  always_comb begin
    c0      = next_port(last_i);
    c1      = next_port(c0);
    c2      = next_port(c1);
    valid_o = |req_i;
    idx_o   = c0;
    if (req_i[c2]) idx_o = c2;
    if (req_i[c1]) idx_o = c1;
    if (req_i[c0]) idx_o = c0;
  end
`else
  localparam logic [3:0] MW4 = 4'(MAX_WAIT);

  always_comb begin
    valid_o = |req_i;
    idx_o   = PORT_CPU;
    if (req_i[1] && (wait1_i == MW4))      idx_o = PORT_DL;
    else if (req_i[2] && (wait2_i == MW4)) idx_o = PORT_ERASE;
    else if (req_i[0])                     idx_o = PORT_CPU;
    else if (req_i[1])                     idx_o = PORT_DL;
    else if (req_i[2])                     idx_o = PORT_ERASE;
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between CPU, downloader and eraser, one access at a time.
// Build macro ARB_ROUND_ROBIN_EN swaps fixed priority/starvation counters for round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ACC_LAT  = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ena,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  output logic [2:0]        ack,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              sd_wr,
  output logic              sd_rd,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  input  logic [DATA_W-1:0] sd_dout
);

  // state | meaning
  // IDLE  | arbitrate; on a winner latch its command and raise sd_wr/sd_rd
  // ISSUE | command visible for its single cycle; load latency counter
  // WAIT  | count down; at zero pulse ack and capture read data
  // DONE  | ack drops, busy drops

  localparam int LW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(ACC_LAT - 1);

  state_e            state_q;
  logic [1:0]        win_q;
  logic              we_q;
  logic [LW-1:0]     lat_q;
  logic [2:0]        ack_q;
  logic [DATA_W-1:0] dout_q;
  logic              busy_q, wr_q, rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  logic [1:0]        pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;
  logic              we_d;
  logic              grant;

  assign grant = (state_q == IDLE) && pick_valid;

  always_comb begin
    addr_d = addr0;
    din_d  = din0;
    we_d   = we[0];
    case (pick_idx)
      PORT_DL:    begin addr_d = addr1; din_d = din1; we_d = we[1]; end
      PORT_ERASE: begin addr_d = addr2; din_d = din2; we_d = we[2]; end
      default:    ;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  sdram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .req_i   (req),
    .last_i  (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n)         ptr_q <= PORT_ERASE;
    else if (ena && grant) ptr_q <= pick_idx;
  end
`else
  localparam logic [3:0] MW4 = 4'(MAX_WAIT);

  logic [3:0] wait1_q, wait2_q, wait1_d, wait2_d;

  sdram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .req_i   (req),
    .wait1_i (wait1_q),
    .wait2_i (wait2_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Losses only count at an actual arbitration; idle requesters forget their history.
  always_comb begin
    wait1_d = wait1_q;
    wait2_d = wait2_q;
    if (!req[1])                          wait1_d = 4'd0;
    else if (grant && pick_idx == PORT_DL) wait1_d = 4'd0;
    else if (grant && wait1_q < MW4)       wait1_d = wait1_q + 4'd1;
    if (!req[2])                              wait2_d = 4'd0;
    else if (grant && pick_idx == PORT_ERASE) wait2_d = 4'd0;
    else if (grant && wait2_q < MW4)          wait2_d = wait2_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait1_q <= 4'd0;
      wait2_q <= 4'd0;
    end else if (ena) begin
      wait1_q <= wait1_d;
      wait2_q <= wait2_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      we_q    <= 1'b0;
      lat_q   <= '0;
      ack_q   <= 3'b000;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win_q   <= pick_idx;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wr_q    <= we_d;
            rd_q    <= !we_d;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wr_q    <= 1'b0;
          rd_q    <= 1'b0;
          lat_q   <= LAT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == '0) begin
            ack_q <= 3'b001 << win_q;
            if (!we_q) dout_q <= sd_dout;
            state_q <= DONE;
          end else begin
            lat_q <= lat_q - LW'(1);
          end
        end
        DONE: begin
          ack_q   <= 3'b000;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign sd_wr   = wr_q;
  assign sd_rd   = rd_q;
  assign sd_addr = addr_q;
  assign sd_din  = din_q;

endmodule
